taxi_pcie_us_msi_arb: RTL

TAXI_PCIE_US_MSI_ARB -- requirements
Module: taxi_pcie_us_msi_arb

---
 rtl/taxi_pcie_us_msi_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/taxi_pcie_us_msi_arb.sv
// taxi_pcie_us_msi_arb: round-robin arbiter turning per-requester interrupt requests into MSI pulses.
// One MSI in flight at a time; a failed or timed-out attempt is re-queued.
module taxi_pcie_us_msi_arb #(
    parameter int IRQ_N   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_N-1:0] irq_req,
    input  logic [3:0]       cfg_interrupt_msi_enable,
    input  logic [11:0]      cfg_interrupt_msi_mmenable,
    output logic [31:0]      cfg_interrupt_msi_int,
    input  logic             cfg_interrupt_msi_sent,
    input  logic             cfg_interrupt_msi_fail,
    output logic [3:0]       cfg_interrupt_msi_function_number,
    output logic [3:0]       cfg_interrupt_msi_select,
    output logic [IRQ_N-1:0] irq_pending,
    output logic             busy,
    output logic             timeout_event
);
    localparam int IW = IRQ_N > 1 ? $clog2(IRQ_N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t           state_q, state_d;
    logic [IRQ_N-1:0] pending_q, pending_d, clr, set;
    logic [IW-1:0]    rr_q, rr_d, grant_q, grant_d, gidx, rr_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      msi_q, msi_d;
    logic             en_q, found, grant, tmo, done, retry;
    logic [2:0]       mexp;
    logic [4:0]       vec;
    logic             unused_ok;

    assign unused_ok = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            int j;
            j = int'(rr_q) + i;
            if (j >= IRQ_N) j = j - IRQ_N;
            if (!found && pending_q[j]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
        grant   = state_q == ST_IDLE && en_q && found;
        tmo     = state_q == ST_WAIT && !cfg_interrupt_msi_sent && !cfg_interrupt_msi_fail
                  && cnt_q == CW'(TIMEOUT - 1);
        retry   = state_q == ST_WAIT && (cfg_interrupt_msi_fail || tmo);
        done    = state_q == ST_WAIT && (cfg_interrupt_msi_sent || retry);
        for (int i = 0; i < IRQ_N; i++) begin
            clr[i] = grant && gidx == IW'(i);
            set[i] = retry && grant_q == IW'(i);
        end
        pending_d = (pending_q & ~clr) | set | irq_req;
        // Vectors beyond the enabled message count alias onto the low vectors.
        mexp    = cfg_interrupt_msi_mmenable[2:0] > 3'd5 ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
        vec     = 5'(gidx) & 5'((32'd1 << mexp) - 32'd1);
        msi_d   = grant ? 32'd1 << vec : '0;
        rr_next = grant_q == IW'(IRQ_N - 1) ? '0 : grant_q + IW'(1);
        state_d = grant ? ST_WAIT : done ? ST_IDLE : state_q;
        grant_d = grant ? gidx : grant_q;
        rr_d    = done ? rr_next : rr_q;
        cnt_d   = grant ? '0 : state_q == ST_WAIT ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            msi_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            msi_q     <= msi_d;
            en_q      <= cfg_interrupt_msi_enable[0];
        end
    end

    assign cfg_interrupt_msi_int             = msi_q;
    assign cfg_interrupt_msi_function_number = 4'd0;
    assign cfg_interrupt_msi_select          = 4'd0;
    assign irq_pending                       = pending_q;
    assign busy                              = state_q == ST_WAIT;
    assign timeout_event                     = tmo;
endmodule
